lut_divider_2b: RTL and testbench

//   Sequential radix-4 unsigned divider: the inverse of the 2-bit LUT multiplier.

---
 rtl/lut_divider_2b.sv | 123 ++++++++++++
 tb/tb_lut_divider_2b.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lut_divider_2b.sv
// lut_divider_2b: sequential radix-4 unsigned divider, two quotient bits per clock from a {0,D,2D,3D} table
module lut_divider_2b #(
   parameter int WIDTH = 32
) (
   input  logic             clk_2b,
   input  logic             reset_2b,
   input  logic             start_2b,
   input  logic [WIDTH-1:0] dividend_2b,
   input  logic [WIDTH-1:0] divisor_2b,
   output logic             busy_2b,
   output logic             done_2b,
   output logic [WIDTH-1:0] quotient_2b,
   output logic [WIDTH-1:0] remainder_2b,
   output logic             div_by_zero_2b
);
   localparam int CW = $clog2(WIDTH / 2);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH+1:0] r_q, r_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH+1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] qo_q, qo_d, ro_q, ro_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH+1:0] t, sub, r_nx;
   logic [1:0]       qd;
   logic [WIDTH-1:0] q_nx;
   logic             last;
   assign t    = (WIDTH+2)'({r_q, n_q[WIDTH-1:WIDTH-2]});
   assign qd   = t >= m3_q ? 2'd3 : t >= m2_q ? 2'd2 : t >= m1_q ? 2'd1 : 2'd0;
   assign sub  = qd == 2'd3 ? m3_q : qd == 2'd2 ? m2_q : qd == 2'd1 ? m1_q : '0;
   assign r_nx = t - sub;
   assign q_nx = {quo_q[WIDTH-3:0], qd};
   assign last = cnt_q == CW'(WIDTH / 2 - 1);
   assign busy_2b        = state_q == S_LOAD || state_q == S_ITER;
   assign done_2b        = state_q == S_DONE;
   assign quotient_2b    = qo_q;
   assign remainder_2b   = ro_q;
   assign div_by_zero_2b = dbz_q;
   // next-state and datapath: capture, table build, one radix-4 digit per ITER cycle, result publish
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      d_d     = d_q;
      r_d     = r_q;
      quo_d   = quo_q;
      m1_d    = m1_q;
      m2_d    = m2_q;
      m3_d    = m3_q;
      cnt_d   = cnt_q;
      qo_d    = qo_q;
      ro_d    = ro_q;
      dbz_d   = dbz_q;
      if (state_q == S_IDLE) begin
         if (start_2b) begin
            n_d     = dividend_2b;
            d_d     = divisor_2b;
            r_d     = '0;
            quo_d   = '0;
            state_d = divisor_2b == '0 ? S_DONE : S_LOAD;
            if (divisor_2b == '0) begin
               qo_d  = '1;
               ro_d  = dividend_2b;
               dbz_d = 1'b1;
            end
         end
      end else if (state_q == S_LOAD) begin
         m1_d    = {2'b00, d_q};
         m2_d    = {1'b0, d_q, 1'b0};
         m3_d    = {2'b00, d_q} + {1'b0, d_q, 1'b0};
         cnt_d   = '0;
         state_d = S_ITER;
      end else if (state_q == S_ITER) begin
         n_d   = n_q << 2;
         r_d   = r_nx;
         quo_d = q_nx;
         cnt_d = cnt_q + CW'(1);
         if (last) begin
            state_d = S_DONE;
            qo_d    = q_nx;
            ro_d    = WIDTH'(r_nx);
            dbz_d   = 1'b0;
         end
      end else begin
         state_d = S_IDLE;
      end
   end
   // state registers, cleared asynchronously so a reset aborts any division in flight
   always_ff @(posedge clk_2b or posedge reset_2b) begin
      if (reset_2b) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         quo_q   <= '0;
         m1_q    <= '0;
         m2_q    <= '0;
         m3_q    <= '0;
         cnt_q   <= '0;
         qo_q    <= '0;
         ro_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         d_q     <= d_d;
         r_q     <= r_d;
         quo_q   <= quo_d;
         m1_q    <= m1_d;
         m2_q    <= m2_d;
         m3_q    <= m3_d;
         cnt_q   <= cnt_d;
         qo_q    <= qo_d;
         ro_q    <= ro_d;
         dbz_q   <= dbz_d;
      end
   end
endmodule

// File: tb/tb_lut_divider_2b.sv
// tb_lut_divider_2b: randomized and directed checks of lut_divider_2b against a cycle-count/arithmetic model
module tb_lut_divider_2b;
   localparam int W = 32;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] n = '0;
   logic [W-1:0] d = '0;
   logic         busy, done, dbz;
   logic [W-1:0] q, r;
   int checks = 0;
   int errors = 0;
   bit           m_active = 1'b0;
   int           m_rem = 0;
   logic [W-1:0] e_q = '0, e_r = '0, l_q = '0, l_r = '0, l_n = '0, l_d = '0, c_n = '0, c_d = '0;
   bit           e_dbz = 1'b0, l_dbz = 1'b0;
   int           accepts = 0;

   lut_divider_2b #(.WIDTH(W)) dut (
      .clk_2b(clk), .reset_2b(rst), .start_2b(start), .dividend_2b(n), .divisor_2b(d),
      .busy_2b(busy), .done_2b(done), .quotient_2b(q), .remainder_2b(r), .div_by_zero_2b(dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: an accepted start publishes N/D and N%D after WIDTH/2+1 further edges (0 for D==0)
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0; m_rem = 0;
         e_q = '0; e_r = '0; e_dbz = 1'b0;
      end else if (m_active) begin
         if (m_rem == 0) m_active = 1'b0;
         else begin
            m_rem--;
            if (m_rem == 0) begin
               e_q = l_q; e_r = l_r; e_dbz = l_dbz; c_n = l_n; c_d = l_d;
            end
         end
      end else if (start) begin
         accepts++;
         m_active = 1'b1;
         l_n = n; l_d = d;
         if (d == '0) begin
            m_rem = 0;
            e_q = '1; e_r = n; e_dbz = 1'b1; c_n = n; c_d = d;
         end else begin
            m_rem = W / 2 + 1;
            l_q = n / d; l_r = n % d; l_dbz = 1'b0;
         end
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("done", {63'b0, done}, {63'b0, m_active && m_rem == 0});
         chk("busy", {63'b0, busy}, {63'b0, m_active && m_rem > 0});
         chk("quotient", {32'b0, q}, {32'b0, e_q});
         chk("remainder", {32'b0, r}, {32'b0, e_r});
         chk("div_by_zero", {63'b0, dbz}, {63'b0, e_dbz});
         if (done && !dbz) begin
            chk("q_times_d_plus_r", {32'b0, q} * {32'b0, c_d} + {32'b0, r}, {32'b0, c_n});
            chk("r_lt_d", {63'b0, r < c_d}, 64'd1);
         end
         if (dut.d_q != '0) chk("invariant_r_lt_d", {63'b0, dut.r_q < {2'b00, dut.d_q}}, 64'd1);
      end
   end

   task automatic run_op(input logic [W-1:0] nn, input logic [W-1:0] dd, output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; n = nn; d = dd;
      lat = 0; bcnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (done) begin lat = i; break; end
         if (busy) bcnt++;
      end
      if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_done(input string name);
      int seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (seen == 0) chk(name, 64'd0, 64'd1);
   endtask

   initial begin
      int lat, bcnt, cyc, a0, nd;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_quotient", {32'b0, q}, 64'd0);
      chk("reset_remainder", {32'b0, r}, 64'd0);
      chk("reset_flags", {61'b0, busy, done, dbz}, 64'd0);
      rst = 1'b0;
      run_op(32'd100, 32'd7, lat, bcnt);
      chk("t1_q", {32'b0, q}, 64'd14);
      chk("t1_r", {32'b0, r}, 64'd2);
      chk("t1_dbz", {63'b0, dbz}, 64'd0);
      chk("t1_latency", lat, 64'd18);
      chk("t1_busy_cycles", bcnt, 64'd17);
      run_op(32'hFFFF_FFFF, 32'd1, lat, bcnt);
      chk("t2a_q", {32'b0, q}, 64'hFFFF_FFFF);
      chk("t2a_r", {32'b0, r}, 64'd0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      chk("t2b_q", {32'b0, q}, 64'd1);
      chk("t2b_r", {32'b0, r}, 64'd0);
      run_op(32'd5, 32'd0, lat, bcnt);
      chk("t3_q", {32'b0, q}, 64'hFFFF_FFFF);
      chk("t3_r", {32'b0, r}, 64'd5);
      chk("t3_dbz", {63'b0, dbz}, 64'd1);
      chk("t3_latency", lat, 64'd1);
      chk("t3_busy_cycles", bcnt, 64'd0);
      @(negedge clk);
      start = 1'b1; n = 32'd3; d = 32'd10;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; n = 32'd9; d = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done("t4_done_timeout");
      chk("t4_q", {32'b0, q}, 64'd0);
      chk("t4_r", {32'b0, r}, 64'd3);
      @(negedge clk);
      start = 1'b1; n = 32'd1000; d = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t5_reset_q", {32'b0, q}, 64'd0);
      chk("t5_reset_r", {32'b0, r}, 64'd0);
      chk("t5_reset_flags", {61'b0, busy, done, dbz}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(32'd1000, 32'd9, lat, bcnt);
      chk("t5_q", {32'b0, q}, 64'd111);
      chk("t5_r", {32'b0, r}, 64'd1);
      cyc = 0;
      a0 = accepts;
      while (accepts - a0 < 2000 && cyc < 90000) begin
         @(negedge clk);
         cyc++;
         start = $urandom_range(3) != 0;
         nd = $urandom_range(7);
         d = nd == 0 ? 32'd0 : nd == 1 ? W'($urandom_range(3, 1)) : nd == 2 ? W'($urandom_range(255, 1)) :
             nd == 3 ? 32'hFFFF_FFFF : W'($urandom);
         nd = $urandom_range(3);
         n = nd == 0 ? (d == '0 ? 32'd0 : W'($urandom) % d) : nd == 1 ? W'($urandom_range(15)) : W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      chk("random_accepts_reached", {63'b0, accepts - a0 >= 2000}, 64'd1);
      repeat (25) @(negedge clk);
      chk("drained_idle", {62'b0, busy, done}, 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
